// File: rtl/alu_lock_arbiter_pkg.sv
// rtl/alu_lock_arbiter_pkg.sv - shared ALU op/request/answer types for the ALU lock arbiter
package alu_lock_arbiter_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDU = 4'd1,
      OP_SUB  = 4'd2,
      OP_SUBU = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOR  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9,
      OP_LUI  = 4'd10,
      OP_SLL  = 4'd11,
      OP_SRL  = 4'd12,
      OP_SRA  = 4'd13
   } alu_op_t;

   typedef struct packed {
      alu_op_t            op;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
   } alu_req_t;

   typedef struct packed {
      logic [DATA_W-1:0]  c;
      logic               zero;
   } alu_ans_t;

   // Owner index width; a single-unit configuration still needs one bit.
   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_lock_arbiter_if.sv
// rtl/alu_lock_arbiter_if.sv - request/grant/operand bundle between SIC units and the ALU arbiter
interface alu_lock_arbiter_if
   import alu_lock_arbiter_pkg::*;
#(
   parameter int NUM_SIC  = 4,
   parameter int ID_WIDTH = 4
) ();

   logic [NUM_SIC-1:0]               rpl_req;
   logic [NUM_SIC-1:0][ID_WIDTH-1:0] rpl_issue_id;
   logic [NUM_SIC-1:0]               rpl_release;
   alu_req_t [NUM_SIC-1:0]           alu_req;
   logic [NUM_SIC-1:0]               alu_grant;
   alu_ans_t [NUM_SIC-1:0]           alu_ans;
   logic                             busy;

   modport master (
      output rpl_req, rpl_issue_id, rpl_release, alu_req,
      input  alu_grant, alu_ans, busy
   );

   modport slave (
      input  rpl_req, rpl_issue_id, rpl_release, alu_req,
      output alu_grant, alu_ans, busy
   );

endinterface

// File: rtl/alu_lock_arbiter_alu_core.sv
// rtl/alu_lock_arbiter_alu_core.sv - combinational 32-bit ALU datapath shared by all SIC units
module alu_core
   import alu_lock_arbiter_pkg::*;
(
   input  alu_op_t           i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_c,
   output logic              o_zero
);

   logic [DATA_W-1:0] w_c;
   logic [4:0]        w_sh;

   assign w_sh = i_b[4:0];

   always_comb begin
      w_c = '0;
      case (i_op)
         OP_ADD, OP_ADDU: w_c = i_a + i_b;
         OP_SUB, OP_SUBU: w_c = i_a - i_b;
         OP_AND:          w_c = i_a & i_b;
         OP_OR:           w_c = i_a | i_b;
         OP_XOR:          w_c = i_a ^ i_b;
         OP_NOR:          w_c = ~(i_a | i_b);
         OP_SLT:          w_c = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         OP_SLTU:         w_c = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
         OP_LUI:          w_c = {i_b[15:0], 16'h0000};
         OP_SLL:          w_c = i_a << w_sh;
         OP_SRL:          w_c = i_a >> w_sh;
         OP_SRA:          w_c = $unsigned($signed(i_a) >>> w_sh);
         default:         w_c = '0;
      endcase
   end

   assign o_c    = w_c;
   assign o_zero = (w_c == '0);

endmodule

// File: rtl/alu_lock_arbiter.sv
// rtl/alu_lock_arbiter.sv - age-ordered lock arbiter granting one SIC unit exclusive use of the ALU
module alu_lock_arbiter
   import alu_lock_arbiter_pkg::*;
#(
   parameter int NUM_SIC  = 4,
   parameter int ID_WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_lock_arbiter_if.slave bus
);

   localparam int OWN_W = owner_w(NUM_SIC);

   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [OWN_W-1:0]     r_owner;
   logic [OWN_W-1:0]     w_owner_nxt;

   logic [NUM_SIC-1:0]   w_own_mask;
   logic [NUM_SIC-1:0]   w_cand;
   logic [NUM_SIC-1:0]   w_grant;
   logic                 w_lock_end;
   logic                 w_found;
   logic [OWN_W-1:0]     w_win;
   logic [ID_WIDTH-1:0]  w_best_id;

   alu_req_t             w_sel_req;
   logic [DATA_W-1:0]    w_c;
   logic                 w_zero;

   always_comb begin
      w_own_mask          = '0;
      w_own_mask[r_owner] = 1'b1;
   end

   // Release pulse and a dropped request both end the lock.
   assign w_lock_end = (r_state == ST_LOCKED) &&
                       ((|(bus.rpl_release & w_own_mask)) || !(|(bus.rpl_req & w_own_mask)));

   assign w_cand = (r_state == ST_LOCKED) ? (bus.rpl_req & ~w_own_mask) : bus.rpl_req;

   // Strict less-than keeps the lowest index on equal issue ids.
   always_comb begin
      w_found   = 1'b0;
      w_win     = '0;
      w_best_id = '0;
      for (int i = 0; i < NUM_SIC; i++) begin
         if (w_cand[i] && (!w_found || (bus.rpl_issue_id[i] < w_best_id))) begin
            w_found   = 1'b1;
            w_win     = OWN_W'(i);
            w_best_id = bus.rpl_issue_id[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_FREE;
         r_owner <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      case (r_state)
         ST_FREE: begin
            if (w_found) begin
               w_state_nxt = ST_LOCKED;
               w_owner_nxt = w_win;
            end
         end
         ST_LOCKED: begin
            if (w_lock_end) begin
               if (w_found) begin
                  w_owner_nxt = w_win;
               end else begin
                  w_state_nxt = ST_FREE;
               end
            end
         end
         default: w_state_nxt = ST_FREE;
      endcase
   end

   assign w_grant   = (r_state == ST_LOCKED) ? w_own_mask : '0;
   assign w_sel_req = bus.alu_req[r_owner];

   alu_core u_alu_core (
      .i_op   (w_sel_req.op),
      .i_a    (w_sel_req.a),
      .i_b    (w_sel_req.b),
      .o_c    (w_c),
      .o_zero (w_zero)
   );

   always_comb begin
      bus.alu_grant = w_grant;
      bus.busy      = (r_state == ST_LOCKED);
      for (int i = 0; i < NUM_SIC; i++) begin
         bus.alu_ans[i] = w_grant[i] ? {w_c, w_zero} : '0;
      end
   end

endmodule

// File: tb/tb_alu_lock_arbiter.sv
// tb/tb_alu_lock_arbiter.sv - self-checking bench for alu_lock_arbiter
module tb_alu_lock_arbiter;
   import alu_lock_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int IDW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_lock_arbiter_if #(.NUM_SIC(N), .ID_WIDTH(IDW)) bus ();

   alu_lock_arbiter #(.NUM_SIC(N), .ID_WIDTH(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        z;
   } alu_vec_t;

   int checks   = 0;
   int failures = 0;
   int m_owner  = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Owner after the coming edge: keep the holder unless it lets go, else oldest id, then lowest index.
   function automatic int ref_next(input int cur);
      int best;
      int best_key;
      int key;
      if (!rst_n) return -1;
      if (cur >= 0 && bus.rpl_req[cur] && !bus.rpl_release[cur]) return cur;
      best     = -1;
      best_key = 1 << 30;
      for (int i = 0; i < N; i++) begin
         if (bus.rpl_req[i] && i != cur) begin
            key = int'(bus.rpl_issue_id[i]) * N + i;
            if (key < best_key) begin
               best_key = key;
               best     = i;
            end
         end
      end
      return best;
   endfunction

   function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ext;
      int sh;
      sh = int'(b[4:0]);
      case (op)
         OP_ADD, OP_ADDU: return a + b;
         OP_SUB, OP_SUBU: return a + (~b) + 32'd1;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOR:  return ~(a | b);
         OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
         OP_LUI:  return b * 32'd65536;
         OP_SLL:  return a * (32'd1 << sh);
         OP_SRL:  return a / (32'd1 << sh);
         OP_SRA: begin
            ext = {{32{a[31]}}, a} >> sh;
            return ext[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic tick();
      int nxt;
      nxt = ref_next(m_owner);
      @(posedge clk);
      #1;
      m_owner = nxt;
   endtask

   task automatic check_model(input string name);
      logic [N-1:0] g;
      g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      check({name, "_grant"}, 64'(bus.alu_grant), 64'(g));
      check({name, "_busy"}, 64'(bus.busy), 64'(m_owner >= 0));
   endtask

   task automatic clear_inputs();
      bus.rpl_req      = '0;
      bus.rpl_release  = '0;
      bus.rpl_issue_id = '0;
      bus.alu_req      = '0;
   endtask

   alu_vec_t tbl[$];
   logic [32:0] exp_ans;
   logic [31:0] rc;

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_grant", 64'(bus.alu_grant), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_ans", 64'(bus.alu_ans), 64'd0);

      // Single requester with ADD
      rst_n = 1'b1;
      bus.rpl_req = 4'b0010;
      bus.rpl_issue_id[1] = 4'd3;
      bus.alu_req[1] = '{op: OP_ADD, a: 32'd5, b: 32'd7};
      tick();
      check("single_grant", 64'(bus.alu_grant), 64'b0010);
      check("single_busy", 64'(bus.busy), 64'd1);
      check("single_ans1", 64'(bus.alu_ans[1]), 64'({32'd12, 1'b0}));
      check("single_ans0", 64'(bus.alu_ans[0]), 64'd0);
      bus.rpl_req = '0;
      tick();
      check("single_free", 64'(bus.alu_grant), 64'd0);

      // Age priority and zero-bubble handoff
      bus.rpl_req = 4'b0101;
      bus.rpl_issue_id[0] = 4'd9;
      bus.rpl_issue_id[2] = 4'd2;
      tick();
      check("age_grant", 64'(bus.alu_grant), 64'b0100);
      tick();
      check("age_hold", 64'(bus.alu_grant), 64'b0100);
      bus.rpl_release = 4'b0100;
      tick();
      check("age_handoff", 64'(bus.alu_grant), 64'b0001);
      bus.rpl_release = '0;
      bus.rpl_req = 4'b0001;
      tick();
      check("age_hold0", 64'(bus.alu_grant), 64'b0001);
      clear_inputs();
      tick();
      check("age_free", 64'(bus.busy), 64'd0);

      // Tie and no preemption
      bus.rpl_req = 4'b1000;
      bus.rpl_issue_id[3] = 4'd5;
      tick();
      check("tie_own3", 64'(bus.alu_grant), 64'b1000);
      bus.rpl_req = 4'b1011;
      bus.rpl_issue_id[0] = 4'd1;
      bus.rpl_issue_id[1] = 4'd1;
      tick();
      check("tie_nopreempt", 64'(bus.alu_grant), 64'b1000);
      bus.rpl_release = 4'b1000;
      tick();
      check("tie_lowidx", 64'(bus.alu_grant), 64'b0001);
      clear_inputs();
      tick();

      // Abort path: owner drops request, late release ignored
      bus.rpl_req = 4'b0010;
      bus.rpl_issue_id[1] = 4'd4;
      tick();
      bus.rpl_req = '0;
      tick();
      check("abort_clear", 64'(bus.alu_grant), 64'd0);
      bus.rpl_req = 4'b0010;
      tick();
      bus.rpl_req = 4'b0110;
      bus.rpl_issue_id[2] = 4'd6;
      tick();
      check("abort_hold", 64'(bus.alu_grant), 64'b0010);
      bus.rpl_req = 4'b0100;
      tick();
      check("abort_handoff", 64'(bus.alu_grant), 64'b0100);
      bus.rpl_release = 4'b0010;
      tick();
      check("abort_late_rel", 64'(bus.alu_grant), 64'b0100);
      clear_inputs();
      tick();

      // ALU vector table through SIC0
      tbl.push_back('{OP_SUB,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1});
      tbl.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
      tbl.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
      tbl.push_back('{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0});
      tbl.push_back('{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
      tbl.push_back('{OP_SUBU, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0});
      tbl.push_back('{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
      tbl.push_back('{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0});
      tbl.push_back('{OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0});
      tbl.push_back('{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
      tbl.push_back('{OP_LUI,  32'h1234_5678, 32'h0001_ABCD, 32'hABCD_0000, 1'b0});
      tbl.push_back('{OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0});
      tbl.push_back('{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0});
      tbl.push_back('{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
      tbl.push_back('{OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
      tbl.push_back('{alu_op_t'(4'd15), 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1});
      bus.rpl_req = 4'b0001;
      tick();
      for (int k = 0; k < tbl.size(); k++) begin
         bus.alu_req[0] = '{op: tbl[k].op, a: tbl[k].a, b: tbl[k].b};
         bus.alu_req[1] = '{op: OP_NOR, a: 32'd0, b: 32'd0};
         #1;
         check($sformatf("alu_vec%0d", k), 64'(bus.alu_ans[0]), 64'({tbl[k].c, tbl[k].z}));
      end
      check("alu_nonowner", 64'(bus.alu_ans[1]), 64'd0);
      clear_inputs();
      tick();

      // Reset mid-lock
      bus.rpl_req = 4'b0100;
      bus.rpl_issue_id[2] = 4'd2;
      tick();
      check("rstmid_own2", 64'(bus.alu_grant), 64'b0100);
      bus.rpl_req = 4'b0110;
      bus.rpl_issue_id[1] = 4'd7;
      bus.alu_req[2] = '{op: OP_NOR, a: 32'd0, b: 32'd0};
      rst_n = 1'b0;
      tick();
      check("rstmid_grant", 64'(bus.alu_grant), 64'd0);
      check("rstmid_busy", 64'(bus.busy), 64'd0);
      check("rstmid_ans", 64'(bus.alu_ans), 64'd0);
      rst_n = 1'b1;
      bus.rpl_req = 4'b0010;
      tick();
      check("rstmid_regrant", 64'(bus.alu_grant), 64'b0010);
      clear_inputs();
      tick();

      // Randomized arbitration and datapath against the reference model
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst_n           = ($urandom_range(0, 59) != 0);
         bus.rpl_req     = N'($urandom);
         bus.rpl_release = N'($urandom & $urandom & $urandom);
         for (int i = 0; i < N; i++) begin
            bus.rpl_issue_id[i] = IDW'($urandom_range(0, 3));
            bus.alu_req[i].op   = alu_op_t'(4'($urandom_range(0, 15)));
            bus.alu_req[i].a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            bus.alu_req[i].b    = ($urandom_range(0, 7) == 0) ? bus.alu_req[i].a : $urandom;
         end
         #1;
         for (int i = 0; i < N; i++) begin
            rc = ref_alu(bus.alu_req[i].op, bus.alu_req[i].a, bus.alu_req[i].b);
            exp_ans = (i == m_owner) ? {rc, (rc == 32'd0)} : 33'd0;
            check($sformatf("rnd_ans%0d_c%0d", i, cyc), 64'(bus.alu_ans[i]), 64'(exp_ans));
         end
         tick();
         check_model($sformatf("rnd_c%0d", cyc));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
